// File: rtl/module_rx_pkg.sv
// Shared types and the correction function for the Hamming(7,4) receive corrector.
package module_rx_pkg;

  typedef logic [6:0] codeword_t;
  typedef logic [2:0] syndrome_t;
  typedef logic [3:0] nibble_t;

  typedef struct packed {
    nibble_t   d;
    codeword_t cw;
    logic      err;
    syndrome_t err_pos;
  } corr_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Index i selects the codeword bit that lands on d[i]; d = {cw[6], cw[5], cw[4], cw[2]}.
  localparam logic [2:0] DATA_POS [4] = '{3'd2, 3'd4, 3'd5, 3'd6};

  localparam codeword_t CW_ONE = 7'd1;

  function automatic corr_entry_t correct(input codeword_t e, input syndrome_t s);
    corr_entry_t r;
    codeword_t   c;
    c = e;
    if (s != 3'd0) c = e ^ (CW_ONE << (s - 3'd1));
    r.cw      = c;
    for (int i = 0; i < 4; i++) r.d[i] = c[DATA_POS[i]];
    r.err     = (s != 3'd0);
    r.err_pos = s;
    return r;
  endfunction

endpackage

// File: rtl/module_rx_fifo2.sv
// Two-entry valid/ready output buffer of corrected entries; head and ready/valid are registered.
module module_rx_fifo2
  import module_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  corr_entry_t din,
  output logic        out_valid,
  input  logic        out_ready,
  output corr_entry_t head
);

  state_t      state;
  corr_entry_t tail;
  logic        push;
  logic        pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      head      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= din;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head     <= tail;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the second slot carries no reset; it is only read after being written in ONE.
  always_ff @(posedge clk) begin
    if (state == ONE && push && !pop) tail <= din;
  end

endmodule

// File: rtl/module_rx_corrector.sv
// Hamming(7,4) receive corrector: flips the syndrome-indicated bit and buffers results.
// Optional RX_CORR_STATS_EN enables the saturating corrected-error counter on err_cnt.
module module_rx_corrector
  import module_rx_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       e,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       d,
  output logic [6:0]       cw,
  output logic             err,
  output logic [2:0]       err_pos,
  output logic [CNT_W-1:0] err_cnt
);

  corr_entry_t fixed;
  corr_entry_t head;

  assign fixed = correct(e, s);

  module_rx_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (fixed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .head      (head)
  );

  assign d       = head.d;
  assign cw      = head.cw;
  assign err     = head.err;
  assign err_pos = head.err_pos;

`ifdef RX_CORR_STATS_EN
  logic push;
  assign push = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (push && s != 3'd0 && err_cnt != {CNT_W{1'b1}}) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_module_rx_corrector.sv
// Directed bench for module_rx_corrector: vector table plus backpressure, saturation and reset sequences.
module tb_module_rx_corrector;

  localparam int CNT_W = 2;
`ifdef RX_CORR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       e = '0;
  logic [2:0]       s = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       d;
  logic [6:0]       cw;
  logic             err;
  logic [2:0]       err_pos;
  logic [CNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  module_rx_corrector #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e         (e),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .cw        (cw),
    .err       (err),
    .err_pos   (err_pos),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [6:0] e;
    logic [2:0] s;
    logic [3:0] d;
    logic [6:0] cw;
    logic       err;
    logic [2:0] pos;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_cnt = 0;
  endtask

  function automatic logic [31:0] exp_cnt();
    return STATS ? 32'(model_cnt) : 32'd0;
  endfunction

  task automatic count_if_err(input logic [2:0] syn);
    if (syn != 3'd0 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
  endtask

  initial begin
    vecs[0] = '{7'b1010101, 3'd0, 4'b1011, 7'b1010101, 1'b0, 3'd0};
    vecs[1] = '{7'b1000101, 3'd5, 4'b1011, 7'b1010101, 1'b1, 3'd5};
    vecs[2] = '{7'b0000000, 3'd0, 4'b0000, 7'b0000000, 1'b0, 3'd0};
    vecs[3] = '{7'b0000001, 3'd1, 4'b0000, 7'b0000000, 1'b1, 3'd1};
    vecs[4] = '{7'b1111111, 3'd7, 4'b0111, 7'b0111111, 1'b1, 3'd7};
    vecs[5] = '{7'b0000000, 3'd3, 4'b0001, 7'b0000100, 1'b1, 3'd3};
    vecs[6] = '{7'b1111111, 3'd2, 4'b1111, 7'b1111101, 1'b1, 3'd2};
    vecs[7] = '{7'b0110011, 3'd4, 4'b0110, 7'b0111011, 1'b1, 3'd4};

    // Reset state
    #1;
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_d",         32'(d),         32'd0);
    check("rst_cw",        32'(cw),        32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_err_pos",   32'(err_pos),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);

    // Streaming vector table: push every cycle with out_ready=1, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      e = vecs[i].e;
      s = vecs[i].s;
      step();
      count_if_err(vecs[i].s);
      check($sformatf("vec%0d_valid", i),    32'(out_valid), 32'd1);
      check($sformatf("vec%0d_ready", i),    32'(in_ready),  32'd1);
      check($sformatf("vec%0d_d", i),        32'(d),         32'(vecs[i].d));
      check($sformatf("vec%0d_cw", i),       32'(cw),        32'(vecs[i].cw));
      check($sformatf("vec%0d_err", i),      32'(err),       32'(vecs[i].err));
      check($sformatf("vec%0d_err_pos", i),  32'(err_pos),   32'(vecs[i].pos));
      check($sformatf("vec%0d_err_cnt", i),  32'(err_cnt),   exp_cnt());
    end
    in_valid = 1'b0;
    e = 7'h7f;
    s = 3'd7;
    step();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_err_cnt",   32'(err_cnt),   exp_cnt());

    // Saturation: five erroneous words, counter sequence 1,2,3,3,3 when enabled
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      e = 7'b0000001;
      s = 3'd1;
      step();
      count_if_err(3'd1);
      check($sformatf("sat%0d_err_cnt", i), 32'(err_cnt), STATS ? 32'((i < 3) ? i + 1 : 3) : 32'd0);
    end
    in_valid = 1'b0;
    step();

    // Backpressure: A, B fill the buffer, C is held off until space frees up
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    e = 7'b1010101; s = 3'd0;
    step();
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_ready", 32'(in_ready),  32'd1);
    check("bp_a_cw",    32'(cw),        32'h55);
    e = 7'b0000001; s = 3'd1;
    step();
    check("bp_b_ready", 32'(in_ready), 32'd0);
    check("bp_b_head",  32'(cw),       32'h55);
    e = 7'b1111111; s = 3'd0;
    step();
    check("bp_c_ready", 32'(in_ready), 32'd0);
    check("bp_c_head",  32'(cw),       32'h55);
    check("bp_c_err",   32'(err),      32'd0);
    out_ready = 1'b1;
    step();
    check("bp_pop_a_head",  32'(cw),       32'h00);
    check("bp_pop_a_err",   32'(err),      32'd1);
    check("bp_pop_a_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_c_head_cw",    32'(cw),        32'h7f);
    check("bp_c_head_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_empty_valid", 32'(out_valid), 32'd0);
    check("bp_err_cnt",     32'(err_cnt),   STATS ? 32'd1 : 32'd0);

    // Mid-stream reset with buffer full and a push attempt on the same edge
    out_ready = 1'b0;
    in_valid = 1'b1;
    e = 7'b0000001; s = 3'd1;
    step();
    e = 7'b1111111; s = 3'd7;
    step();
    check("mr_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    e = 7'b1010101; s = 3'd2;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready",  32'(in_ready),  32'd1);
    check("mr_err_cnt",   32'(err_cnt),   32'd0);
    check("mr_cw",        32'(cw),        32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mr_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/module_rx_corrector.md
# module_rx_corrector

Receive-side error-correction stage for the Hamming(7,4) link. It sits directly downstream of the RX syndrome decoder and consumes each 7-bit codeword together with its 3-bit syndrome. For each pair it flips the indicated bit, extracts the 4 data bits and raises error flags. Results are delivered through a 2-entry valid/ready output buffer to the display/consumer stage.

## Interface
Parameters:
- CNT_W, default 8: width of the saturating corrected-error counter.

Ports (clock and reset first):
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  codeword and syndrome are valid this cycle.
- in_ready  output  1  stage can accept input; transfer occurs when in_valid && in_ready.
- e  input  7  received codeword. Bit e[k] is Hamming position k+1. Parity bits are at positions 1, 2 and 4; data bits at positions 3, 5, 6 and 7.
- s  input  3  syndrome from the decoder. 0 means no error; 1..7 is the erroneous position.
- out_valid  output  1  output buffer head is valid.
- out_ready  input  1  consumer accepts the head; pop occurs when out_valid && out_ready.
- d  output  4  corrected data {e[6],e[5],e[4],e[2]} after correction.
- cw  output  7  corrected codeword.
- err  output  1  head entry had a nonzero syndrome.
- err_pos  output  3  head entry syndrome (position corrected), or 0.
- err_cnt  output  CNT_W  number of accepted words with s != 0. Saturating. Present only with RX_CORR_STATS_EN; otherwise tied to 0.

## Operation
- Correction (combinational on accepted input):
  - corrected = e ^ (7'b1 << (s-1)) when s != 0, else e.
  - d is taken from the corrected word.
  - err = (s != 0); err_pos = s.
- Output buffer is a 2-entry FIFO of {d, cw, err, err_pos}, controlled by an FSM:
  - EMPTY: out_valid=0, in_ready=1. Push → ONE.
  - ONE: out_valid=1, in_ready=1.
    - Push and pop together → ONE; the new entry becomes head in the next cycle.
    - Push only → TWO.
    - Pop only → EMPTY.
  - TWO: out_valid=1, in_ready=0. Pop → ONE. Input is ignored even if in_valid=1.
- in_ready is a registered function of state only (1 in EMPTY/ONE, 0 in TWO). It has no combinational path from out_ready.
- Entries leave in acceptance order. A head entry and its outputs are stable while out_valid && !out_ready.
- err_cnt increments by 1 on each accepted word with s != 0. It holds at 2^CNT_W-1 once it saturates. It is not affected by pops.
- Values on e/s when no transfer occurs are don't-care and must not change state.

## Timing
- Reset (rst=1 at a rising edge): state=EMPTY, out_valid=0, in_ready=1, d=0, cw=0, err=0, err_pos=0, err_cnt=0. Buffer contents are discarded.
- Reset applied mid-operation discards buffered entries in the same edge. A simultaneous push is dropped.
- Latency: an accepted word appears on out_valid/d in the next cycle when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: one word per cycle while out_ready=1.
- Output d/cw/err/err_pos are registered (buffer head). There is no combinational input-to-output path.
- err_cnt updates in the cycle after the accepting edge.

## Configuration
- RX_CORR_STATS_EN defined: err_cnt register and increment/saturation logic are present.
- RX_CORR_STATS_EN undefined: err_cnt is driven constant 0 and no counter flops are synthesized. All other behaviour is identical.

## Structure
- Shared package module_rx_pkg holds:
  - typedefs codeword_t (logic [6:0]), syndrome_t (logic [2:0]), nibble_t (logic [3:0]);
  - the corr_entry_t struct {nibble_t d; codeword_t cw; logic err; syndrome_t err_pos};
  - the state enum {EMPTY, ONE, TWO};
  - constant DATA_POS = {6,5,4,2}.
- Optional sub-module module_rx_fifo2: a generic 2-entry valid/ready buffer of corr_entry_t containing the FSM. Correction logic and the counter stay in the top module.

## Test plan
- No error: with out_ready=1, push e=7'b1010101, s=0 → next cycle out_valid=1, d=4'b1011, cw=7'b1010101, err=0, err_pos=0; err_cnt stays 0.
- Single error: push e=7'b1000101, s=3'b101 → cw=7'b1010101, d=4'b1011, err=1, err_pos=5; err_cnt=1 (macro defined) or 0 (undefined).
- Backpressure: with out_ready=0, push words A, B, then hold in_valid with C → in_ready=0 after B; C not accepted. Raise out_ready → A, then B appear in order; C is accepted once in_ready=1.
- Simultaneous push/pop in ONE → state stays ONE with one word per cycle; 10 back-to-back words all delivered in order with no drops.
- Saturation: CNT_W=2, push 5 words with s=1 → err_cnt sequence 1, 2, 3, 3, 3.
- Mid-stream reset: with the buffer in TWO, assert rst for 1 cycle → out_valid=0, in_ready=1, err_cnt=0; old entries never appear.
